maze_move_ctrl: RTL and testbench



---
 rtl/maze_pkg.sv | 32 +++
 rtl/maze_step_decode.sv | 31 +++
 rtl/maze_move_ctrl.sv | 140 ++++++++++++++
 tb/tb_maze_move_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared geometry constants and types for the maze move controller
package maze_pkg;
  localparam int GRID_W        = 6;
  localparam int N_CELLS       = GRID_W * GRID_W;
  localparam int TERMINAL_CELL = N_CELLS;

  typedef logic [5:0] cell_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_CHECK,
    S_MOVE,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } move_fsm_t;

  typedef enum logic [1:0] {
    F_NONE    = 2'd0,
    F_ILLEGAL = 2'd1,
    F_TIMEOUT = 2'd2,
    F_BUDGET  = 2'd3
  } fault_t;
endpackage

// File: rtl/maze_step_decode.sv
// maze_step_decode: classifies a requested cell as a legal single step from the current cell and gives its direction
module maze_step_decode #(
  parameter int GRID_W = 6
) (
  input  logic [5:0] cur_i,
  input  logic [5:0] nxt_i,
  output logic       legal_o,
  output logic [1:0] dir_o
);
  import maze_pkg::*;

  localparam logic [6:0] W  = 7'(GRID_W);
  localparam logic [6:0] NC = 7'(GRID_W * GRID_W);

  logic [6:0] c, n;
  logic       same_row, up, down, left, right;

  assign c        = {1'b0, cur_i};
  assign n        = {1'b0, nxt_i};
  assign same_row = (c / W) == (n / W);
  assign up       = (n + W) == c;
  assign down     = (c + W) == n;
  assign left     = ((n + 7'd1) == c) && same_row;
  assign right    = ((c + 7'd1) == n) && same_row;

  // Horizontal steps must stay inside the row so 5->6 style wraps are rejected.
  always_comb begin
    legal_o = (n < NC) && (up || down || left || right);
    dir_o   = up ? DIR_UP : down ? DIR_DOWN : left ? DIR_LEFT : DIR_RIGHT;
  end
endmodule

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: turns exploit-stage cell requests into handshaked moves; MOVE_SIM_EN replaces move_ack with an internal ack
module maze_move_ctrl #(
  parameter int GRID_W          = 6,
  parameter int MOVE_TIMEOUT    = 50_000_000,
  parameter int MAX_STEPS       = 64,
  parameter int SIM_MOVE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] start_state,
  input  logic [5:0] target_state,
  input  logic [5:0] next_state,
  input  logic       timer_start,
  input  logic       move_ack,
  output logic       move_req,
  output logic [1:0] move_dir,
  output logic [5:0] maze_state,
  output logic       move_complete,
  output logic [6:0] step_count,
  output logic       target_reached,
  output logic       fault,
  output logic [1:0] fault_code
);
  import maze_pkg::*;

  localparam int CNT_MAX = MOVE_TIMEOUT > SIM_MOVE_CYCLES ? MOVE_TIMEOUT : SIM_MOVE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  move_fsm_t     state_q, state_d;
  cell_t         maze_q, maze_d, pend_q, pend_d;
  dir_t          dir_q, dir_d;
  fault_t        code_q, code_d;
  logic [6:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, done_q, tgt_q, flt_q;
  logic          legal, ack;
  logic [1:0]    dec_dir;

  maze_step_decode #(.GRID_W(GRID_W)) u_dec (
    .cur_i   (maze_q),
    .nxt_i   (pend_q),
    .legal_o (legal),
    .dir_o   (dec_dir)
  );

`ifdef MOVE_SIM_EN
  assign ack = cnt_q == CW'(SIM_MOVE_CYCLES - 1);
`else
  assign ack = move_ack;
`endif

  // Next-state logic: run control, step check, move handshake with timeout, commit and budget check.
  always_comb begin
    state_d = state_q;
    maze_d  = maze_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    code_d  = code_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: if (start) begin
        maze_d  = start_state;
        step_d  = '0;
        code_d  = F_NONE;
        state_d = S_READY;
      end
      S_READY: if (maze_q == target_state) begin
        state_d = S_DONE;
      end else if (timer_start) begin
        pend_d  = next_state;
        state_d = S_CHECK;
      end
      S_CHECK: if (legal) begin
        dir_d   = dir_t'(dec_dir);
        cnt_d   = '0;
        state_d = S_MOVE;
      end else begin
        code_d  = F_ILLEGAL;
        state_d = S_FAULT;
      end
      S_MOVE: if (ack) begin
        maze_d  = pend_q;
        step_d  = step_q == 7'd127 ? step_q : step_q + 7'd1;
        state_d = S_SETTLE;
      end else if (cnt_q == CW'(MOVE_TIMEOUT - 1)) begin
        code_d  = F_TIMEOUT;
        state_d = S_FAULT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_SETTLE: if (step_q == 7'(MAX_STEPS) && pend_q != target_state) begin
        code_d  = F_BUDGET;
        state_d = S_FAULT;
      end else begin
        state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; status flags are decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      maze_q  <= '0;
      pend_q  <= '0;
      dir_q   <= DIR_UP;
      code_q  <= F_NONE;
      step_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      tgt_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      maze_q  <= maze_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      code_q  <= code_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      req_q   <= state_d == S_MOVE;
      done_q  <= state_d == S_SETTLE;
      tgt_q   <= state_d == S_DONE;
      flt_q   <= state_d == S_FAULT;
    end
  end

  assign move_req       = req_q;
  assign move_dir       = dir_q;
  assign maze_state     = maze_q;
  assign move_complete  = done_q;
  assign step_count     = step_q;
  assign target_reached = tgt_q;
  assign fault          = flt_q;
  assign fault_code     = code_q;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: directed checks of moves, illegal steps, timeout, step budget, target priority and reset
module tb_maze_move_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] start_state = '0;
  logic [5:0] target_state = '0;
  logic [5:0] next_state = '0;
  logic       timer_start = 1'b0;
  logic       move_ack = 1'b0;
  logic       move_req;
  logic [1:0] move_dir;
  logic [5:0] maze_state;
  logic       move_complete;
  logic [6:0] step_count;
  logic       target_reached;
  logic       fault;
  logic [1:0] fault_code;

  int n_chk = 0;
  int n_err = 0;
  int mc_total = 0;

  maze_move_ctrl #(
    .GRID_W          (6),
    .MOVE_TIMEOUT    (100),
    .MAX_STEPS       (4),
    .SIM_MOVE_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_state    (start_state),
    .target_state   (target_state),
    .next_state     (next_state),
    .timer_start    (timer_start),
    .move_ack       (move_ack),
    .move_req       (move_req),
    .move_dir       (move_dir),
    .maze_state     (maze_state),
    .move_complete  (move_complete),
    .step_count     (step_count),
    .target_reached (target_reached),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (move_complete) mc_total <= mc_total + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input logic [5:0] st, input logic [5:0] tg);
    start = 1'b1;
    start_state = st;
    target_state = tg;
    tick();
    start = 1'b0;
  endtask

  task automatic do_move(input logic [5:0] nxt, input int dly, input int exp_dir);
    timer_start = 1'b1;
    next_state = nxt;
    tick();
    timer_start = 1'b0;
    check("check_no_req", move_req, 0);
    tick();
    check("move_req_on", move_req, 1);
    check("move_dir", move_dir, exp_dir);
    repeat (dly) tick();
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check("complete_pulse", move_complete, 1);
    check("commit_cell", maze_state, nxt);
    check("req_drop", move_req, 0);
  endtask

  initial begin
    int base;
    int req_cycles;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_maze", maze_state, 0);
    check("rst_step", step_count, 0);
    check("rst_dir", move_dir, 0);
    check("rst_code", fault_code, 0);
    check("rst_flags", {move_req, move_complete, target_reached, fault}, 0);

    base = mc_total;
    run(6'd0, 6'd2);
    check("t1_start_cell", maze_state, 0);
    do_move(6'd1, 4, 3);
    check("t1_step1", step_count, 1);
    tick();
    check("t1_pulse_one_cycle", move_complete, 0);
    do_move(6'd2, 0, 3);
    check("t1_step2", step_count, 2);
    tick();
    check("t1_not_yet_target", target_reached, 0);
    tick();
    check("t1_target", target_reached, 1);
    check("t1_complete_count", mc_total - base, 2);

    run(6'd5, 6'd35);
    timer_start = 1'b1;
    next_state = 6'd6;
    tick();
    timer_start = 1'b0;
    check("wrap_no_req", move_req, 0);
    tick();
    check("wrap_fault", fault, 1);
    check("wrap_code", fault_code, 1);
    check("wrap_req", move_req, 0);

    run(6'd14, 6'd35);
    check("to_fault_cleared", fault, 0);
    timer_start = 1'b1;
    next_state = 6'd8;
    tick();
    timer_start = 1'b0;
    tick();
    check("to_dir_up", move_dir, 0);
    req_cycles = 0;
    for (int i = 0; i < 300 && !fault; i++) begin
      if (move_req) req_cycles++;
      tick();
    end
    check("to_req_cycles", req_cycles, 100);
    check("to_fault", fault, 1);
    check("to_code", fault_code, 2);
    check("to_req_drop", move_req, 0);

    base = mc_total;
    run(6'd0, 6'd35);
    do_move(6'd1, 0, 3);
    tick();
    do_move(6'd0, 0, 2);
    tick();
    do_move(6'd1, 0, 3);
    check("bud_step3", step_count, 3);
    tick();
    check("bud_no_fault3", fault, 0);
    do_move(6'd0, 0, 2);
    check("bud_step4", step_count, 4);
    tick();
    check("bud_fault", fault, 1);
    check("bud_code", fault_code, 3);
    check("bud_step_hold", step_count, 4);
    check("bud_complete_count", mc_total - base, 4);

    run(6'd7, 6'd7);
    timer_start = 1'b1;
    next_state = 6'd8;
    tick();
    timer_start = 1'b0;
    check("prio_target", target_reached, 1);
    tick();
    check("prio_no_req", move_req, 0);
    check("prio_cell", maze_state, 7);

    run(6'd0, 6'd35);
    timer_start = 1'b1;
    next_state = 6'd6;
    tick();
    timer_start = 1'b0;
    tick();
    check("rst_mid_req", move_req, 1);
    check("rst_mid_dir", move_dir, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_drop", move_req, 0);
    check("rst_mid_cell", maze_state, 0);
    run(6'd20, 6'd35);
    check("rst_restart_cell", maze_state, 20);

    do_move(6'd19, 1, 2);
    tick();
    do_move(6'd25, 0, 1);
    tick();
    timer_start = 1'b1;
    next_state = 6'd25;
    tick();
    timer_start = 1'b0;
    tick();
    check("same_fault", fault, 1);
    check("same_code", fault_code, 1);

    run(6'd35, 6'd0);
    timer_start = 1'b1;
    next_state = 6'd36;
    tick();
    timer_start = 1'b0;
    tick();
    check("oob_fault", fault, 1);
    check("oob_code", fault_code, 1);
    check("oob_cell", maze_state, 35);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
